// File: rtl/snake_draw_pkg.sv
// Shared constants and types for the draw-chain stages of the snake display.
package snake_draw_pkg;

  localparam int unsigned CHAR_W      = 8;
  localparam int unsigned CHAR_H      = 16;
  localparam int unsigned TXT_COLS    = 16;
  localparam int unsigned TXT_ROWS    = 16;
  localparam int unsigned HCNT_W      = 11;
  localparam int unsigned RGB_W       = 12;
  localparam int unsigned TXT_LATENCY = 5;

  typedef struct packed {
    logic [HCNT_W-1:0] hcount;
    logic [HCNT_W-1:0] vcount;
    logic              hsync;
    logic              vsync;
    logic              hblnk;
    logic              vblnk;
    logic [RGB_W-1:0]  rgb;
  } vga_sig_t;

  // Font rows are stored with bit 7 as the leftmost pixel.
  function automatic logic glyph_bit(input logic [7:0] line, input logic [2:0] x);
    return line[3'd7 - x];
  endfunction

endpackage

// File: rtl/draw_text_overlay_if.sv
// Address/data bundle between the text overlay and its text and font ROMs.
interface draw_text_overlay_if;

  logic [7:0]  char_xy;
  logic [6:0]  char_code;
  // {char_code, row_in_char}
  logic [10:0] font_addr;
  logic [7:0]  font_line;

  modport master (
    output char_xy,
    output font_addr,
    input  char_code,
    input  font_line
  );

  modport slave (
    input  char_xy,
    input  font_addr,
    output char_code,
    output font_line
  );

endinterface

// File: rtl/draw_delay_line.sv
// Reset-clearable shift register; dout is din delayed by DEPTH clocks.
module draw_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/draw_text_overlay.sv
// 16x16 character text box overlaid on the VGA pixel stream; fixed 5-cycle latency,
// driving external registered text and font ROMs.
module draw_text_overlay
  import snake_draw_pkg::*;
#(
  parameter int unsigned      X_POS        = 0,
  parameter int unsigned      Y_POS        = 0,
  parameter logic [RGB_W-1:0] TXT_COLOR    = 12'hfff,
  parameter int unsigned      BLINK_FRAMES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [HCNT_W-1:0] hcount_in,
  input  logic [HCNT_W-1:0] vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic [RGB_W-1:0]  rgb_in,
  draw_text_overlay_if.master rom,
  output logic [HCNT_W-1:0] hcount_out,
  output logic [HCNT_W-1:0] vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              hblnk_out,
  output logic              vblnk_out,
  output logic [RGB_W-1:0]  rgb_out
);

  localparam int unsigned BoxW = TXT_COLS * CHAR_W;
  localparam int unsigned BoxH = TXT_ROWS * CHAR_H;
  localparam int unsigned CntW = (BLINK_FRAMES > 0) ? $clog2(BLINK_FRAMES + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);

  // Offsets computed at 32 bits: a pixel left of/above the box wraps to a huge value,
  // so a single unsigned compare covers both edges without wrapping at 11 bits.
  logic [31:0] dx, dy;
  logic        in_box;

  assign dx     = 32'(hcount_in) - X_POS;
  assign dy     = 32'(vcount_in) - Y_POS;
  assign in_box = (dx < BoxW) && (dy < BoxH);

  // Stage 1: ROM address and side-band.
  logic [7:0] char_xy_d, char_xy_q;
  logic       in_box_q;
  logic [2:0] x_q;
  logic [3:0] row_q;

  assign char_xy_d = in_box ? {dy[7:4], dx[6:3]} : 8'h00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      char_xy_q <= '0;
      in_box_q  <= 1'b0;
      x_q       <= '0;
      row_q     <= '0;
    end else begin
      char_xy_q <= char_xy_d;
      in_box_q  <= in_box;
      x_q       <= dx[2:0];
      row_q     <= dy[3:0];
    end
  end

  assign rom.char_xy = char_xy_q;

  // Row lines up with char_code, which the text ROM returns one cycle after char_xy.
  logic [3:0] row_d2;

  draw_delay_line #(
    .WIDTH(4),
    .DEPTH(1)
  ) u_row_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (row_q),
    .dout (row_d2)
  );

  logic [10:0] font_addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      font_addr_q <= '0;
    end else begin
      font_addr_q <= {rom.char_code, row_d2};
    end
  end

  assign rom.font_addr = font_addr_q;

  // in_box and x_in_char travel alongside until font_line arrives.
  logic [3:0] side_d4;
  logic       in_box_d4;
  logic [2:0] x_d4;

  draw_delay_line #(
    .WIDTH(4),
    .DEPTH(TXT_LATENCY - 2)
  ) u_side_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({in_box_q, x_q}),
    .dout (side_d4)
  );

  assign in_box_d4 = side_d4[3];
  assign x_d4      = side_d4[2:0];

  vga_sig_t vga_in, vga_d4, out_d, out_q;

  assign vga_in = '{
    hcount: hcount_in,
    vcount: vcount_in,
    hsync:  hsync_in,
    vsync:  vsync_in,
    hblnk:  hblnk_in,
    vblnk:  vblnk_in,
    rgb:    rgb_in
  };

  draw_delay_line #(
    .WIDTH($bits(vga_sig_t)),
    .DEPTH(TXT_LATENCY - 1)
  ) u_vga_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (vga_in),
    .dout (vga_d4)
  );

  // Blink state: counts vsync rising edges, toggles visibility every BLINK_FRAMES frames.
  logic            vsync_q;
  logic [CntW-1:0] frame_cnt_q;
  logic            visible_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      frame_cnt_q <= '0;
      visible_q   <= 1'b1;
    end else begin
      vsync_q <= vsync_in;
      if ((BLINK_FRAMES != 0) && vsync_in && !vsync_q) begin
        if (frame_cnt_q == CntLast) begin
          frame_cnt_q <= '0;
          visible_q   <= !visible_q;
        end else begin
          frame_cnt_q <= frame_cnt_q + CntW'(1);
        end
      end
    end
  end

  logic pixel_on;

  assign pixel_on = glyph_bit(rom.font_line, x_d4);

  always_comb begin
    out_d = vga_d4;
    if (in_box_d4 && pixel_on && visible_q && !vga_d4.hblnk && !vga_d4.vblnk) begin
      out_d.rgb = TXT_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign hcount_out = out_q.hcount;
  assign vcount_out = out_q.vcount;
  assign hsync_out  = out_q.hsync;
  assign vsync_out  = out_q.vsync;
  assign hblnk_out  = out_q.hblnk;
  assign vblnk_out  = out_q.vblnk;
  assign rgb_out    = out_q.rgb;

endmodule
